// File: rtl/sr_stack_pkg.sv
//------------------------------------------------------------------------------
// Module   : sr_stack_pkg
// Brief    : FSM state and error-code encodings shared by the stack unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sr_stack_pkg;

  typedef enum logic [1:0] {
    S_RUN = 2'd0,
    S_OVF = 2'd1,
    S_UNF = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  function automatic logic [1:0] err_code_of(input state_t s);
    case (s)
      S_OVF:   return ERR_OVF;
      S_UNF:   return ERR_UNF;
      default: return ERR_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_stack_mem.sv
//------------------------------------------------------------------------------
// Module   : sr_stack_mem
// Brief    : DEPTH x DATA_W storage, asynchronous read, synchronous write.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_stack_mem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sr_stack_unit.sv
//------------------------------------------------------------------------------
// Module   : sr_stack_unit
// Brief    : Hardware LIFO for stack.push / stack.pop with sticky error FSM.
//            Optional high-water mark enabled by macro SR_STACK_PEAK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_stack_unit
  import sr_stack_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic [DATA_W-1:0] pop_data,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  peak
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q;
  logic [1:0]         err_code_q;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [ADDR_W-1:0]  top_addr;
  logic [DATA_W-1:0]  top_data;
  logic               is_empty;
  logic               is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  // At count==DEPTH the low bits are zero, so the decrement wraps to DEPTH-1.
  assign top_addr = count_q[ADDR_W-1:0] - ADDR_W'(1);

  sr_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (push_data),
    .raddr (top_addr),
    .rdata (top_data)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = count_q[ADDR_W-1:0];
    pop_data  = '0;
    case (state_q)
      S_RUN: begin
        pop_data = is_empty ? '0 : top_data;
        if (push_req && pop_req) begin
          if (is_empty) begin
            pop_data = push_data;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = top_addr;
          end
        end else if (push_req) begin
          if (is_full) begin
            state_d = S_OVF;
          end else begin
            mem_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end else if (pop_req) begin
          if (is_empty) begin
            state_d = S_UNF;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      S_OVF, S_UNF: begin
        if (err_clr) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= (state_d != S_RUN);
      err_code_q <= err_code_of(state_d);
    end
  end

`ifdef SR_STACK_PEAK_EN
  logic [CNT_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_stack_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_sr_stack_unit
// Brief    : Self-checking bench for sr_stack_unit (DEPTH=4) with queue model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_stack_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push_req = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_req = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] pop_data;
  logic [CW-1:0] count;
  logic          empty, full, err;
  logic [1:0]    err_code;
  logic [CW-1:0] peak;

  sr_stack_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_req(push_req), .push_data(push_data),
    .pop_req(pop_req), .pop_data(pop_data), .err_clr(err_clr),
    .count(count), .empty(empty), .full(full), .err(err),
    .err_code(err_code), .peak(peak)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the stack is a queue, the mode is 0 run / 1 ovf / 2 unf.
  logic [DW-1:0] stk [$];
  int            mode  = 0;
  int            mpeak = 0;
  logic [DW-1:0] obs_pop, exp_pop;

  function automatic logic [CW-1:0] exp_peak();
`ifdef SR_STACK_PEAK_EN
    return CW'(mpeak);
`else
    return '0;
`endif
  endfunction

  // One clock cycle: inputs applied after negedge, pop_data sampled before
  // the edge, registered outputs settle #1 after the posedge.
  task automatic step(input logic r, input logic p, input logic [DW-1:0] d,
                      input logic q, input logic c);
    @(negedge clk);
    rst = r; push_req = p; push_data = d; pop_req = q; err_clr = c;
    #1;
    obs_pop = pop_data;
    if (mode == 0) begin
      if (p && q && stk.size() == 0) exp_pop = d;
      else exp_pop = (stk.size() > 0) ? stk[$] : '0;
    end else begin
      exp_pop = '0;
    end
    if (r) begin
      stk.delete();
      mode  = 0;
      mpeak = 0;
    end else if (mode == 0) begin
      if (p && q) begin
        if (stk.size() > 0) stk[$] = d;
      end else if (p) begin
        if (stk.size() == DEPTH) mode = 1;
        else stk.push_back(d);
      end else if (q) begin
        if (stk.size() == 0) mode = 2;
        else void'(stk.pop_back());
      end
    end else if (c) begin
      mode = 0;
    end
    if (!r && stk.size() > mpeak) mpeak = stk.size();
    @(posedge clk);
    #1;
    rst = 1'b0; push_req = 1'b0; pop_req = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, '0, 0, 0);
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
    n_cmp++; if (err !== 1'b0 || err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b/%b want 0/00", err, err_code); end
    n_cmp++; if (peak !== 3'd0) begin n_fail++; $display("FAIL reset_peak got %0d want 0", peak); end
  endtask

  task automatic test_lifo();
    logic [DW-1:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, vals[i], 0, 0);
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL lifo_count got %0d want 3", count); end
    for (int i = 2; i >= 0; i--) begin
      step(0, 0, '0, 1, 0);
      n_cmp++; if (obs_pop !== vals[i]) begin n_fail++; $display("FAIL lifo_pop%0d got %h want %h", i, obs_pop, vals[i]); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    step(1, 0, '0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 32'hA0 + DW'(i), 0, 0);
    step(0, 1, 32'hDEAD, 0, 0);
    n_cmp++; if (full !== 1'b1 || err !== 1'b1 || err_code !== 2'b01) begin n_fail++; $display("FAIL ovf_flags got full=%b err=%b code=%b want 1 1 01", full, err, err_code); end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
    step(0, 0, '0, 1, 0);
    n_cmp++; if (obs_pop !== 32'h0 || count !== 3'd4) begin n_fail++; $display("FAIL ovf_pop_ignored got pop=%h count=%0d want 0 4", obs_pop, count); end
    step(0, 0, '0, 0, 1);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got err=%b want 0", err); end
    step(0, 0, '0, 1, 0);
    n_cmp++; if (obs_pop !== 32'hA4) begin n_fail++; $display("FAIL ovf_after_clr_pop got %h want a4", obs_pop); end
  endtask

  task automatic test_underflow();
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    n_cmp++; if (obs_pop !== 32'h0 || err_code !== 2'b10 || err !== 1'b1) begin n_fail++; $display("FAIL unf got pop=%h code=%b err=%b want 0 10 1", obs_pop, err_code, err); end
    step(0, 1, 32'h77, 0, 0);
    n_cmp++; if (count !== 3'd0 || err !== 1'b1) begin n_fail++; $display("FAIL unf_push_ignored got count=%0d err=%b want 0 1", count, err); end
    step(0, 1, 32'h78, 0, 1);
    n_cmp++; if (err !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL unf_clr got err=%b count=%0d want 0 0", err, count); end
  endtask

  task automatic test_replace();
    step(1, 0, '0, 0, 0);
    step(0, 1, 32'h99, 0, 0);
    step(0, 1, 32'hAA, 0, 0);
    step(0, 1, 32'hBB, 1, 0);
    n_cmp++; if (obs_pop !== 32'hAA || count !== 3'd2) begin n_fail++; $display("FAIL replace got pop=%h count=%0d want aa 2", obs_pop, count); end
    step(0, 0, '0, 1, 0);
    n_cmp++; if (obs_pop !== 32'hBB) begin n_fail++; $display("FAIL replace_next got %h want bb", obs_pop); end
  endtask

  task automatic test_forward();
    step(1, 0, '0, 0, 0);
    step(0, 1, 32'h55, 1, 0);
    n_cmp++; if (obs_pop !== 32'h55 || count !== 3'd0 || err !== 1'b0) begin n_fail++; $display("FAIL fwd_empty got pop=%h count=%0d err=%b want 55 0 0", obs_pop, count, err); end
    for (int i = 1; i <= 4; i++) step(0, 1, 32'hC0 + DW'(i), 0, 0);
    step(0, 1, 32'h66, 1, 0);
    n_cmp++; if (obs_pop !== 32'hC4 || count !== 3'd4 || err !== 1'b0) begin n_fail++; $display("FAIL fwd_full got pop=%h count=%0d err=%b want c4 4 0", obs_pop, count, err); end
  endtask

  task automatic test_reset_mid_error();
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(i), 0, 0);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rst_err_setup got err=%b want 1", err); end
    step(1, 1, 32'h1, 0, 0);
    n_cmp++; if (count !== 3'd0 || err !== 1'b0 || peak !== 3'd0) begin n_fail++; $display("FAIL rst_mid_err got count=%0d err=%b peak=%0d want 0 0 0", count, err, peak); end
    for (int i = 0; i < 3; i++) step(0, 1, DW'(i), 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 1, 0);
    n_cmp++; if (count !== 3'd1 || peak !== exp_peak()) begin n_fail++; $display("FAIL peak got count=%0d peak=%0d want 1 %0d", count, peak, exp_peak()); end
  endtask

  task automatic test_random();
    logic r, p, q, c;
    step(1, 0, '0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) == 0);
      p = ($urandom_range(0, 1) == 1);
      q = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 3) == 0);
      step(r, p, $urandom, q, c);
      n_cmp++; if (obs_pop !== exp_pop) begin n_fail++; $display("FAIL rnd_pop[%0d] got %h want %h", n, obs_pop, exp_pop); end
      n_cmp++; if (count !== CW'(stk.size()) || empty !== (stk.size() == 0) || full !== (stk.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_count[%0d] got %0d/%b/%b want %0d", n, count, empty, full, stk.size());
      end
      n_cmp++; if (err !== (mode != 0) || err_code !== 2'(mode)) begin n_fail++; $display("FAIL rnd_err[%0d] got %b/%b want mode %0d", n, err, err_code, mode); end
      n_cmp++; if (peak !== exp_peak()) begin n_fail++; $display("FAIL rnd_peak[%0d] got %0d want %0d", n, peak, exp_peak()); end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_replace();
    test_forward();
    test_reset_mid_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sr_stack_unit.md
Name: sr_stack_unit

Overview:
Hardware LIFO serving the CPU's custom stack.push / stack.pop instructions. It sits beside the register file in sr_cpu.
- push writes rs1 data onto the stack.
- pop returns the top-of-stack value in the same cycle, for write-back to rd.
- The pointer update commits on the clock edge.
- Overflow and underflow are trapped by a sticky error FSM, so the testbench and debug logic can observe misuse.

Parameters:
DATA_W, 32, data word width
DEPTH, 16, number of entries (power of two, >= 2)
CNT_W, $clog2(DEPTH)+1, localparam, width of occupancy counter (not overridable)

Ports:
clk  input  1  system clock, the CPU clock
rst  input  1  reset, synchronous, active-high
push_req  input  1  push request, one-cycle strobe per instruction
push_data  input  DATA_W  value to push (rs1 data)
pop_req  input  1  pop request, one-cycle strobe per instruction
pop_data  output  DATA_W  combinational top-of-stack value for the current pop
err_clr  input  1  clears the sticky error state
count  output  CNT_W  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
err  output  1  high in any error state
err_code  output  2  00 none, 01 overflow, 10 underflow
peak  output  CNT_W  high-water mark (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (sampled on a clk edge with rst=1): count=0, state=S_RUN, err=0, err_code=00, peak=0. Memory contents are not reset.
- Outputs in S_RUN:
  - pop_data = mem[count-1] when count>0.
  - pop_data = 0 when empty, except the forwarding case below.
- Outputs in error states: pop_data = 0.
- FSM states: S_RUN, S_OVF, S_UNF. All transitions occur on clk.
- S_RUN, push only:
  - not full: mem[count] <= push_data; count+1.
  - full: no write, count held, go to S_OVF.
- S_RUN, pop only:
  - not empty: count-1.
  - empty: go to S_UNF.
- S_RUN, push+pop together:
  - not empty: replace top, mem[count-1] <= push_data. count unchanged. pop_data shows the old top. No error, including when full.
  - empty: pop_data = push_data (forwarded), count stays 0, no write, no error.
- S_OVF / S_UNF:
  - push_req and pop_req are ignored; count and memory are frozen.
  - err=1; err_code = 01 in S_OVF, 10 in S_UNF.
- err_clr:
  - From an error state: returns to S_RUN on that edge. Requests in the same cycle are ignored.
  - In S_RUN: no effect; requests proceed normally.
- rst has priority over everything, including mid-error and simultaneous requests.
- Latency: pop_data is valid combinationally in the request cycle. count, empty and full update one edge after the request.
- Width rule: count never wraps. It is saturated by the overflow and underflow checks, never by arithmetic.

Optional Feature:
Macro SR_STACK_PEAK_EN.
- Defined: peak is a register, cleared on rst, updated at each clk edge to max(peak, next count). It is not cleared by err_clr.
- Undefined: peak is tied to 0 and no register is inferred. The port list is identical in both builds.

Decomposition:
- sr_stack_pkg holds:
  - FSM state encodings S_RUN=2'd0, S_OVF=2'd1, S_UNF=2'd2;
  - err_code constants ERR_NONE, ERR_OVF, ERR_UNF.
  - The RVOP_PUSH/RVF3_PUSH and RVOP_POP/RVF3_POP opcode constants stay in the existing CPU header; the unit does not decode instructions.
- One sub-module, sr_stack_mem:
  - DEPTH x DATA_W array;
  - asynchronous read port and one synchronous write port (we, waddr, wdata).
  - The top level owns the counter, FSM, forwarding mux and peak.

Test Plan (DEPTH=4, DATA_W=32):
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count=3. Pops return 0x33, 0x22, 0x11 in order; empty=1 afterwards.
- Push 4 values, then a 5th push of 0xDEAD -> full=1, err=1, err_code=01, count stays 4. A further pop is ignored (count=4, pop_data=0). err_clr then a pop -> returns the 4th value.
- Pop with count=0 -> pop_data=0, err_code=10. A push while in S_UNF is ignored (count=0). err_clr -> err=0.
- Push+pop with count=2 and top=0xAA, push_data=0xBB -> pop_data=0xAA, count=2. The next pop returns 0xBB.
- Push+pop with count=0, push_data=0x55 -> pop_data=0x55, count=0, err=0. Same with count=4 -> no overflow.
- Assert rst while in S_OVF with push_req=1 -> next cycle count=0, err=0, peak=0. With SR_STACK_PEAK_EN, pushing 3 and popping 2 -> peak=3.
